// File: rtl/hoaaned_err_monitor.sv
// hoaaned_err_monitor: streaming error-metrics collector for approximate adders.
// Recomputes the exact sum of each accepted (a, b) pair, compares it with the
// approximate sum under test and accumulates error statistics over a window of
// num_samples samples.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, num_samples  window start request (accepted when busy=0) and length
//   in_valid/in_ready   sample handshake; in_ready high only while running
//   in_a, in_b, in_sum  operands and approximate sum under test
//   busy, done          window in progress / single-cycle results-final pulse
//   err_count           samples with nonzero error distance (saturating)
//   err_dist_sum        sum of error distances (saturating)
//   err_dist_max        largest error distance
//   err_sq_sum          sum of squared error distances (saturating), 0 if disabled
//   sat                 sticky: some accumulator saturated in this window
//
// Build option: define HOAANED_ERRMON_SQERR_EN to build the squared-error path.
module hoaaned_err_monitor #(
   parameter int unsigned WIDTH = 14,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned ACC_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [WIDTH:0]       in_sum,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     err_count,
   output logic [ACC_W-1:0]     err_dist_sum,
   output logic [WIDTH:0]       err_dist_max,
   output logic [2*ACC_W-1:0]   err_sq_sum,
   output logic                 sat
);

   localparam int unsigned SW  = WIDTH + 1;
   // Extended widths large enough to hold any accumulator plus one addend.
   localparam int unsigned DW  = ((ACC_W > SW) ? ACC_W : SW) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic              in_ready_d, busy_d, done_d;
   logic              start_acc, accept, last_acc;
   logic [CNT_W-1:0]  num_lat;
   logic [CNT_W-1:0]  smp_cnt;

   logic              s1_valid;
   logic [SW-1:0]     s1_exact;
   logic [SW-1:0]     s1_sum;

   logic [SW-1:0]     ed;
   logic [DW-1:0]     dsum_ext;
   logic              dsum_ovf;
   logic [ACC_W-1:0]  dsum_nxt;
   logic              cnt_ovf;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [SW-1:0]     dmax_nxt;
   logic              sq_ovf;

   // in_ready is a registered copy of (state == RUN), so it can gate accepts.
   assign start_acc = (state == IDLE) && start;
   assign accept    = in_valid && in_ready;
   assign last_acc  = accept && ((smp_cnt + CNT_W'(1)) == num_lat);

   // State register plus registered FSM outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_ready <= in_ready_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (num_samples == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (last_acc) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode; done is raised by the edge that leaves DRAIN
   always_comb begin
      in_ready_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      if (state_nxt == RUN)   in_ready_d = 1'b1;
      if (state_nxt != IDLE)  busy_d     = 1'b1;
      if (state == DRAIN)     done_d     = 1'b1;
   end

   // Stage 2 arithmetic: absolute error distance and saturating updates
   always_comb begin
      ed       = (s1_exact >= s1_sum) ? (s1_exact - s1_sum) : (s1_sum - s1_exact);
      dsum_ext = DW'(err_dist_sum) + DW'(ed);
      dsum_ovf = dsum_ext > DW'({ACC_W{1'b1}});
      dsum_nxt = dsum_ovf ? {ACC_W{1'b1}} : dsum_ext[ACC_W-1:0];
      cnt_ovf  = (ed != '0) && (err_count == {CNT_W{1'b1}});
      cnt_nxt  = err_count;
      if ((ed != '0) && !cnt_ovf) cnt_nxt = err_count + CNT_W'(1);
      dmax_nxt = (ed > err_dist_max) ? ed : err_dist_max;
   end

   // Window bookkeeping, stage 1 capture and stage 2 accumulation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_lat      <= '0;
         smp_cnt      <= '0;
         s1_valid     <= 1'b0;
         s1_exact     <= '0;
         s1_sum       <= '0;
         err_count    <= '0;
         err_dist_sum <= '0;
         err_dist_max <= '0;
         sat          <= 1'b0;
      end else if (start_acc) begin
         num_lat      <= num_samples;
         smp_cnt      <= '0;
         s1_valid     <= 1'b0;
         err_count    <= '0;
         err_dist_sum <= '0;
         err_dist_max <= '0;
         sat          <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_exact <= SW'(in_a) + SW'(in_b);
            s1_sum   <= in_sum;
            smp_cnt  <= smp_cnt + CNT_W'(1);
         end
         if (s1_valid) begin
            err_count    <= cnt_nxt;
            err_dist_sum <= dsum_nxt;
            err_dist_max <= dmax_nxt;
            sat          <= sat | dsum_ovf | cnt_ovf | sq_ovf;
         end
      end
   end

`ifdef HOAANED_ERRMON_SQERR_EN
   localparam int unsigned QW  = 2 * SW;
   localparam int unsigned QAW = 2 * ACC_W;
   localparam int unsigned QXW = ((QAW > QW) ? QAW : QW) + 1;

   logic [QW-1:0]  sq;
   logic [QXW-1:0] sq_ext;

   // Squared error distance and its saturating accumulation
   always_comb begin
      sq     = QW'(ed) * QW'(ed);
      sq_ext = QXW'(err_sq_sum) + QXW'(sq);
      sq_ovf = sq_ext > QXW'({QAW{1'b1}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sq_sum <= '0;
      end else if (start_acc) begin
         err_sq_sum <= '0;
      end else if (s1_valid) begin
         err_sq_sum <= sq_ovf ? {QAW{1'b1}} : sq_ext[QAW-1:0];
      end
   end
`else
   assign sq_ovf     = 1'b0;
   assign err_sq_sum = '0;
`endif

endmodule

// File: tb/tb_hoaaned_err_monitor.sv
// Self-checking bench for hoaaned_err_monitor: directed scenarios plus random
// windows checked against a window-level reference model. A second instance
// with ACC_W=8 shares the stimulus to exercise accumulator saturation.
module tb_hoaaned_err_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_samples = '0;
   logic        in_valid = 1'b0;
   logic [13:0] in_a = '0;
   logic [13:0] in_b = '0;
   logic [14:0] in_sum = '0;

   logic        in_ready, busy, done, sat;
   logic [15:0] err_count;
   logic [31:0] err_dist_sum;
   logic [14:0] err_dist_max;
   logic [63:0] err_sq_sum;

   logic        r8_in_ready, r8_busy, r8_done, r8_sat;
   logic [15:0] r8_err_count;
   logic [7:0]  r8_err_dist_sum;
   logic [14:0] r8_err_dist_max;
   logic [15:0] r8_err_sq_sum;

   hoaaned_err_monitor #(.WIDTH(14), .CNT_W(16), .ACC_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_sum(in_sum), .busy(busy), .done(done), .err_count(err_count),
      .err_dist_sum(err_dist_sum), .err_dist_max(err_dist_max),
      .err_sq_sum(err_sq_sum), .sat(sat)
   );

   hoaaned_err_monitor #(.WIDTH(14), .CNT_W(16), .ACC_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(r8_in_ready), .in_a(in_a), .in_b(in_b),
      .in_sum(in_sum), .busy(r8_busy), .done(r8_done), .err_count(r8_err_count),
      .err_dist_sum(r8_err_dist_sum), .err_dist_max(r8_err_dist_max),
      .err_sq_sum(r8_err_sq_sum), .sat(r8_sat)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // Window contents
   logic [13:0] qa[$];
   logic [13:0] qb[$];
   logic [14:0] qs[$];

   // Observations captured by run_window
   bit          timing_ok, tmo;
   logic [15:0] o_cnt;
   logic [31:0] o_dsum;
   logic [14:0] o_dmax;
   logic [63:0] o_qsum;
   logic        o_sat;
   logic [7:0]  o8_dsum;
   logic [15:0] o8_qsum;
   logic        o8_sat;

   // Expected statistics
   logic [15:0]  e_cnt;
   logic [127:0] e_dsum, e_qsum;
   logic [14:0]  e_dmax;
   bit           e_sat;

   function automatic void clear_q();
      qa.delete(); qb.delete(); qs.delete();
   endfunction

   function automatic void push(input int a, input int b, input int s);
      qa.push_back(14'(a)); qb.push_back(14'(b)); qs.push_back(15'(s));
   endfunction

   // Window-level reference: error distances from the queued triples,
   // accumulated with clamp-at-all-ones for an acc_w-bit accumulator.
   function automatic void model(input int acc_w);
      logic [127:0] lim, qlim;
      longint cnt;
      int ed;
      lim  = (128'd1 << acc_w) - 128'd1;
      qlim = (128'd1 << (2 * acc_w)) - 128'd1;
      cnt = 0; e_dsum = '0; e_qsum = '0; e_dmax = '0; e_sat = 0;
      foreach (qa[i]) begin
         ed = int'(qa[i]) + int'(qb[i]) - int'(qs[i]);
         if (ed < 0) ed = -ed;
         if (ed != 0) cnt++;
         if (cnt > 65535) begin cnt = 65535; e_sat = 1; end
         e_dsum = e_dsum + 128'(ed);
         if (e_dsum > lim) begin e_dsum = lim; e_sat = 1; end
         if (15'(ed) > e_dmax) e_dmax = 15'(ed);
`ifdef HOAANED_ERRMON_SQERR_EN
         e_qsum = e_qsum + 128'(longint'(ed) * longint'(ed));
         if (e_qsum > qlim) begin e_qsum = qlim; e_sat = 1; end
`endif
      end
      e_cnt = 16'(cnt);
   endfunction

   // Drive one window; timing_ok records handshake/done/busy timing
   task automatic run_window(input int n, input bit use_pat, input logic [15:0] pat,
                             input bit ign_start);
      int idx, k, d0;
      bit v;
      timing_ok = 1;
      start = 1'b1; num_samples = 16'(n);
      @(posedge clk); #1;
      start = 1'b0;
      if (busy !== 1'b1) timing_ok = 0;
      idx = 0; k = 0;
      while (idx < n && k < 200) begin
         v = use_pat ? pat[k % 16] : ($urandom_range(0, 3) != 0);
         if (ign_start && k == 1) begin start = 1'b1; num_samples = 16'd2; end
         if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) timing_ok = 0;
         in_valid = v; in_a = qa[idx]; in_b = qb[idx]; in_sum = qs[idx];
         @(posedge clk); #1;
         start = 1'b0;
         if (v) idx++;
         k++;
      end
      in_valid = 1'b0;
      tmo = (idx < n);
      d0 = done_cnt;
      if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) timing_ok = 0;
      @(posedge clk); #1;
      if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) timing_ok = 0;
      o_cnt = err_count; o_dsum = err_dist_sum; o_dmax = err_dist_max;
      o_qsum = err_sq_sum; o_sat = sat;
      o8_dsum = r8_err_dist_sum; o8_qsum = r8_err_sq_sum; o8_sat = r8_sat;
      @(posedge clk); #1;
      if (done !== 1'b0) timing_ok = 0;
      if (done_cnt != d0 + 1) timing_ok = 0;
   endtask

   task automatic test_reset();
      int d0;
      n_cmp++;
      if ({in_ready, busy, done, sat, err_count, err_dist_sum, err_dist_max, err_sq_sum} !== '0) begin
         n_err++; $display("FAIL reset_state got busy=%b ready=%b sum=%0d want all 0", busy, in_ready, err_dist_sum);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      // Mid-window reset: 3 of 5 samples (ed=7 each) accepted
      start = 1'b1; num_samples = 16'd5;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = 14'd10; in_b = 14'd20; in_sum = 15'd37;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (err_dist_sum !== 32'd14) begin
         n_err++; $display("FAIL reset_pre_sum got %0d want 14", err_dist_sum);
      end
      rst = 1'b1; #1;
      n_cmp++;
      if ({in_ready, busy, done, sat, err_count, err_dist_sum, err_dist_max, err_sq_sum} !== '0) begin
         n_err++; $display("FAIL reset_mid got ready=%b busy=%b cnt=%0d sum=%0d max=%0d want all 0",
                           in_ready, busy, err_count, err_dist_sum, err_dist_max);
      end
      @(posedge clk); #1; rst = 1'b0;
      d0 = done_cnt;
      in_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1; in_valid = 1'b0;
      n_cmp++;
      if (done_cnt != d0 || in_ready !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL reset_after got dones=%0d ready=%b busy=%b want 0 0 0",
                           done_cnt - d0, in_ready, busy);
      end
   endtask

   task automatic test_single_error();
      clear_q(); push(0, 0, 'h1FF);
      run_window(1, 1, 16'hFFFF, 0);
      n_cmp++;
      if (!timing_ok || tmo) begin n_err++; $display("FAIL single_timing got ok=%0d want 1", timing_ok); end
      n_cmp++;
      if (o_cnt !== 16'd1 || o_dsum !== 32'd511 || o_dmax !== 15'd511) begin
         n_err++; $display("FAIL single_stats got cnt=%0d sum=%0d max=%0d want 1 511 511", o_cnt, o_dsum, o_dmax);
      end
   endtask

   task automatic test_exact_gaps();
      clear_q();
      push('h3FFF, 1, 'h4000);
      push(123, 456, 579);
      push('h3FFF, 'h3FFF, 'h7FFE);
      push(0, 0, 0);
      run_window(4, 1, 16'b0000_0000_0010_1101, 0);
      n_cmp++;
      if (!timing_ok || tmo) begin n_err++; $display("FAIL gaps_timing got ok=%0d want 1", timing_ok); end
      n_cmp++;
      if (o_cnt !== 16'd0 || o_dsum !== 32'd0 || o_dmax !== 15'd0 || o_sat !== 1'b0) begin
         n_err++; $display("FAIL gaps_stats got cnt=%0d sum=%0d max=%0d sat=%b want 0 0 0 0", o_cnt, o_dsum, o_dmax, o_sat);
      end
   endtask

   task automatic test_mixed();
      clear_q();
      push(1000, 2000, 3005);
      push(50, 60, 10);
      push('h1FFF, 'h1FFF, 'h3FFC);
      run_window(3, 0, '0, 1);
      n_cmp++;
      if (!timing_ok || tmo) begin n_err++; $display("FAIL mixed_timing got ok=%0d want 1", timing_ok); end
      n_cmp++;
      if (o_cnt !== 16'd3 || o_dsum !== 32'd107 || o_dmax !== 15'd100 || o_sat !== 1'b0) begin
         n_err++; $display("FAIL mixed_stats got cnt=%0d sum=%0d max=%0d sat=%b want 3 107 100 0", o_cnt, o_dsum, o_dmax, o_sat);
      end
   endtask

   task automatic test_zero_window();
      clear_q();
      run_window(0, 0, '0, 0);
      n_cmp++;
      if (!timing_ok) begin n_err++; $display("FAIL zero_timing got ok=%0d want 1", timing_ok); end
      n_cmp++;
      if (o_cnt !== 16'd0 || o_dsum !== 32'd0 || o_dmax !== 15'd0 || o_qsum !== 64'd0 || o_sat !== 1'b0) begin
         n_err++; $display("FAIL zero_stats got cnt=%0d sum=%0d max=%0d want 0 0 0", o_cnt, o_dsum, o_dmax);
      end
   endtask

   task automatic test_saturation();
      clear_q(); push(0, 0, 200); push(0, 0, 200);
      run_window(2, 0, '0, 0);
      model(8);
      n_cmp++;
      if (o8_dsum !== 8'd255 || o8_sat !== 1'b1) begin
         n_err++; $display("FAIL sat8_sum got sum=%0d sat=%b want 255 1", o8_dsum, o8_sat);
      end
      n_cmp++;
      if (o8_qsum !== e_qsum[15:0]) begin
         n_err++; $display("FAIL sat8_sq got %0d want %0d", o8_qsum, e_qsum[15:0]);
      end
      n_cmp++;
      if (o_dsum !== 32'd400 || o_sat !== 1'b0) begin
         n_err++; $display("FAIL sat32_sum got sum=%0d sat=%b want 400 0", o_dsum, o_sat);
      end
      clear_q(); push(10, 10, 23); push(10, 10, 16);
      run_window(2, 0, '0, 0);
      model(32);
      n_cmp++;
`ifdef HOAANED_ERRMON_SQERR_EN
      if (o_qsum !== 64'd25) begin n_err++; $display("FAIL sq_sum got %0d want 25", o_qsum); end
`else
      if (o_qsum !== 64'd0) begin n_err++; $display("FAIL sq_sum got %0d want 0", o_qsum); end
`endif
      n_cmp++;
      if (o8_dsum !== 8'd7 || o8_sat !== 1'b0) begin
         n_err++; $display("FAIL sat8_clear got sum=%0d sat=%b want 7 0", o8_dsum, o8_sat);
      end
   endtask

   task automatic test_random();
      int n, a, b, s, kind;
      for (int w = 0; w < 25; w++) begin
         n = $urandom_range(1, 12);
         clear_q();
         for (int i = 0; i < n; i++) begin
            a = $urandom_range(0, 16383); b = $urandom_range(0, 16383);
            kind = $urandom_range(0, 3);
            if (kind == 0)      s = a + b;
            else if (kind == 1) s = (a + b + $urandom_range(1, 40)) % 32768;
            else                s = $urandom_range(0, 32767);
            push(a, b, s);
         end
         run_window(n, 0, '0, 0);
         n_cmp++;
         if (!timing_ok || tmo) begin n_err++; $display("FAIL rand_timing w=%0d got ok=%0d want 1", w, timing_ok); end
         model(32);
         n_cmp++;
         if (o_cnt !== e_cnt || o_dsum !== e_dsum[31:0] || o_dmax !== e_dmax ||
             o_qsum !== e_qsum[63:0] || o_sat !== e_sat) begin
            n_err++; $display("FAIL rand_stats w=%0d got cnt=%0d sum=%0d max=%0d sq=%0d sat=%b want %0d %0d %0d %0d %b",
                              w, o_cnt, o_dsum, o_dmax, o_qsum, o_sat, e_cnt, e_dsum[31:0], e_dmax, e_qsum[63:0], e_sat);
         end
         model(8);
         n_cmp++;
         if (o8_dsum !== e_dsum[7:0] || o8_qsum !== e_qsum[15:0] || o8_sat !== e_sat) begin
            n_err++; $display("FAIL rand8_stats w=%0d got sum=%0d sq=%0d sat=%b want %0d %0d %b",
                              w, o8_dsum, o8_qsum, o8_sat, e_dsum[7:0], e_qsum[15:0], e_sat);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_single_error();
      test_exact_gaps();
      test_mixed();
      test_zero_window();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
